// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg: shared types and constants for the RV32I hazard controller.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    // Memory stage wins over writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter: W-bit event counter that sticks at its maximum value.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_Inc,
    output logic [W-1:0] count
);

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset)
            count <= '0;
        else if (i_Inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit: stall/flush/forward control plus data-memory wait handshake.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [4:0]       i_Rs1D,
    input  logic [4:0]       i_Rs2D,
    input  logic [4:0]       i_Rs1E,
    input  logic [4:0]       i_Rs2E,
    input  logic [4:0]       i_RdE,
    input  logic [4:0]       i_RdM,
    input  logic [4:0]       i_RdW,
    input  logic             i_RegWriteM,
    input  logic             i_RegWriteW,
    input  logic [1:0]       i_ResultSrcE,
    input  logic             i_PCSrcE,
    input  logic             i_MemReadM,
    input  logic             i_MemWriteM,
    input  logic             i_MemAckM,
    output logic             o_StallF,
    output logic             o_StallD,
    output logic             o_StallE,
    output logic             o_StallM,
    output logic             o_FlushD,
    output logic             o_FlushE,
    output logic             o_FlushW,
    output logic [1:0]       o_ForwardAE,
    output logic [1:0]       o_ForwardBE,
    output logic             o_MemReqM,
    output logic             o_MemBusy,
    output logic             o_MemErr,
    output logic [CNT_W-1:0] o_LoadUseCnt,
    output logic [CNT_W-1:0] o_FlushCnt,
    output logic [CNT_W-1:0] o_MemWaitCnt
);

    mem_state_t  state, state_next;
    logic [15:0] wait_cnt;
    logic        mem_err;
    logic        mem_stall;
    logic        lw_stall;

    assign o_ForwardAE = fwd_sel(i_Rs1E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
    assign o_ForwardBE = fwd_sel(i_Rs2E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);

    assign o_MemReqM = i_MemReadM | i_MemWriteM;
    assign mem_stall = o_MemReqM & ~i_MemAckM;
    assign lw_stall  = (i_ResultSrcE == RES_LOAD) && (i_RdE != 5'd0) &&
                       ((i_Rs1D == i_RdE) || (i_Rs2D == i_RdE));

    // A memory stall freezes F..M; load-use and branch flush are held off
    // and re-appear on their own once the frozen E stage is released.
    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        o_FlushW = 1'b0;
        if (mem_stall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_StallM = 1'b1;
            o_FlushW = 1'b1;
        end else begin
            o_StallF = lw_stall;
            o_StallD = lw_stall;
            o_FlushD = i_PCSrcE;
            o_FlushE = lw_stall | i_PCSrcE;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mem_stall) state_next = WAIT;
            WAIT: if (i_MemAckM || !o_MemReqM) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state    <= IDLE;
            wait_cnt <= 16'd0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE)
                wait_cnt <= 16'd0;
            else if (wait_cnt != 16'(TIMEOUT))
                wait_cnt <= wait_cnt + 16'd1;
            // Sets on the edge that completes the TIMEOUT-th wait cycle.
            if ((state == WAIT) && (wait_cnt == 16'(TIMEOUT - 1)))
                mem_err <= 1'b1;
        end
    end

    assign o_MemBusy = (state == WAIT);
    assign o_MemErr  = mem_err;

    sat_counter #(.W(CNT_W)) u_load_use_cnt (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Inc   (lw_stall & ~mem_stall),
        .count   (o_LoadUseCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Inc   (i_PCSrcE & ~mem_stall),
        .count   (o_FlushCnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Inc   (mem_stall),
        .count   (o_MemWaitCnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit: table vectors plus hand-written wait/timeout/saturation runs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_unit;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       regwm, regww;
        logic [1:0] ressrc;
        logic       pcsrc, memrd, memwr, ack;
    } in_t;

    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        logic       req, busy, err;
    } out_t;

    typedef struct packed {
        in_t  vin;
        out_t vexp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, pcsrc, memrd, memwr, ack;
    logic [1:0] ressrc;

    logic        a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_req, a_busy, a_err;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_lu, a_fl, a_mw;
    logic        b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_req, b_busy, b_err;
    logic [1:0]  b_fa, b_fb;
    logic [1:0]  b_lu, b_fl, b_mw;

    hazard_unit #(.CNT_W(16), .TIMEOUT(4)) u_dut_a (
        .i_Clk(clk), .i_Reset(rst_n),
        .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e), .i_Rs2E(rs2e), .i_RdE(rde),
        .i_RdM(rdm), .i_RdW(rdw), .i_RegWriteM(regwm), .i_RegWriteW(regww),
        .i_ResultSrcE(ressrc), .i_PCSrcE(pcsrc), .i_MemReadM(memrd),
        .i_MemWriteM(memwr), .i_MemAckM(ack),
        .o_StallF(a_sf), .o_StallD(a_sd), .o_StallE(a_se), .o_StallM(a_sm),
        .o_FlushD(a_fd), .o_FlushE(a_fe), .o_FlushW(a_fw),
        .o_ForwardAE(a_fa), .o_ForwardBE(a_fb), .o_MemReqM(a_req),
        .o_MemBusy(a_busy), .o_MemErr(a_err),
        .o_LoadUseCnt(a_lu), .o_FlushCnt(a_fl), .o_MemWaitCnt(a_mw)
    );

    hazard_unit #(.CNT_W(2), .TIMEOUT(4)) u_dut_b (
        .i_Clk(clk), .i_Reset(rst_n),
        .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e), .i_Rs2E(rs2e), .i_RdE(rde),
        .i_RdM(rdm), .i_RdW(rdw), .i_RegWriteM(regwm), .i_RegWriteW(regww),
        .i_ResultSrcE(ressrc), .i_PCSrcE(pcsrc), .i_MemReadM(memrd),
        .i_MemWriteM(memwr), .i_MemAckM(ack),
        .o_StallF(b_sf), .o_StallD(b_sd), .o_StallE(b_se), .o_StallM(b_sm),
        .o_FlushD(b_fd), .o_FlushE(b_fe), .o_FlushW(b_fw),
        .o_ForwardAE(b_fa), .o_ForwardBE(b_fb), .o_MemReqM(b_req),
        .o_MemBusy(b_busy), .o_MemErr(b_err),
        .o_LoadUseCnt(b_lu), .o_FlushCnt(b_fl), .o_MemWaitCnt(b_mw)
    );

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    function automatic out_t mk(input logic sf, sd, se, sm, fd, fe, fw,
                                input logic [1:0] fa, fb,
                                input logic req, busy, err);
        out_t o;
        o.sf = sf; o.sd = sd; o.se = se; o.sm = sm;
        o.fd = fd; o.fe = fe; o.fw = fw;
        o.fa = fa; o.fb = fb;
        o.req = req; o.busy = busy; o.err = err;
        return o;
    endfunction

    task automatic drive(input in_t v);
        rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e;
        rde = v.rde; rdm = v.rdm; rdw = v.rdw;
        regwm = v.regwm; regww = v.regww; ressrc = v.ressrc;
        pcsrc = v.pcsrc; memrd = v.memrd; memwr = v.memwr; ack = v.ack;
    endtask

    task automatic pop_check(input string name);
        out_t e, a;
        e = exp_q.pop_front();
        a = mk(a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_fa, a_fb,
               a_req, a_busy, a_err);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One cycle: drive after the rising edge, sample on the falling edge.
    task automatic apply(input in_t v, input out_t e, input string name);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(e);
        @(negedge clk);
        pop_check(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive('0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    in_t  t, idle, acc, lu;
    out_t stall_all, none;

    initial begin
        idle      = '0;
        none      = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0);
        stall_all = mk(1,1,1,1,0,0,1,2'b00,2'b00,1,0,0);

        t = '0; t.rdm = 5; t.rdw = 5; t.regwm = 1; t.regww = 1; t.rs1e = 5;
        vecs.push_back('{t, mk(0,0,0,0,0,0,0,2'b10,2'b00,0,0,0)});
        t.regwm = 0;
        vecs.push_back('{t, mk(0,0,0,0,0,0,0,2'b01,2'b00,0,0,0)});
        t = '0; t.regwm = 1; t.regww = 1;
        vecs.push_back('{t, none});
        t = '0; t.rs2e = 9; t.rdw = 9; t.regww = 1; t.rdm = 3; t.regwm = 1;
        vecs.push_back('{t, mk(0,0,0,0,0,0,0,2'b00,2'b01,0,0,0)});
        t = '0; t.rs2e = 4; t.rdm = 4; t.rdw = 4; t.regwm = 1; t.regww = 1;
        vecs.push_back('{t, mk(0,0,0,0,0,0,0,2'b00,2'b10,0,0,0)});
        t = '0; t.ressrc = 2'b01; t.rde = 7; t.rs2d = 7;
        vecs.push_back('{t, mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0,0)});
        t = '0; t.ressrc = 2'b01;
        vecs.push_back('{t, none});
        t = '0; t.ressrc = 2'b10; t.rde = 7; t.rs1d = 7;
        vecs.push_back('{t, none});
        t = '0; t.pcsrc = 1;
        vecs.push_back('{t, mk(0,0,0,0,1,1,0,2'b00,2'b00,0,0,0)});
        t = '0; t.ressrc = 2'b01; t.rde = 3; t.rs1d = 3; t.pcsrc = 1;
        vecs.push_back('{t, mk(1,1,0,0,1,1,0,2'b00,2'b00,0,0,0)});
        t = '0; t.memrd = 1; t.ack = 1;
        vecs.push_back('{t, mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,0)});
        t = '0; t.memwr = 1; t.ack = 1;
        vecs.push_back('{t, mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,0)});
        vecs.push_back('{idle, none});

        acc = '0; acc.memrd = 1;
        lu  = '0; lu.ressrc = 2'b01; lu.rde = 7; lu.rs2d = 7;

        // Reset state, with a pending access visible combinationally.
        drive(acc);
        #2;
        exp_q.push_back(stall_all);
        pop_check("reset_comb");
        chk("reset_lu", a_lu, 0);
        chk("reset_mw", a_mw, 0);
        do_reset();

        foreach (vecs[i])
            apply(vecs[i].vin, vecs[i].vexp, $sformatf("vec%0d", i));
        apply(idle, none, "vec_tail");
        chk("tbl_lu_a", a_lu, 2);
        chk("tbl_fl_a", a_fl, 2);
        chk("tbl_mw_a", a_mw, 0);
        chk("tbl_lu_b", 16'(b_lu), 2);

        // Three-cycle-late ack with a branch pending during the stall.
        do_reset();
        t = acc; t.pcsrc = 1;
        apply(t, stall_all, "mw_c0");
        apply(t, mk(1,1,1,1,0,0,1,2'b00,2'b00,1,1,0), "mw_c1");
        apply(t, mk(1,1,1,1,0,0,1,2'b00,2'b00,1,1,0), "mw_c2");
        t = acc; t.ack = 1;
        apply(t, mk(0,0,0,0,0,0,0,2'b00,2'b00,1,1,0), "mw_ack");
        apply(idle, none, "mw_idle");
        chk("mw_cnt", a_mw, 3);
        chk("mw_flcnt", a_fl, 0);

        // Timeout: six wait cycles, error after the fourth.
        do_reset();
        apply(acc, stall_all, "to_c0");
        for (int i = 1; i <= 6; i++)
            apply(acc, mk(1,1,1,1,0,0,1,2'b00,2'b00,1,1,(i >= 5) ? 1'b1 : 1'b0),
                  $sformatf("to_c%0d", i));
        t = acc; t.ack = 1;
        apply(t, mk(0,0,0,0,0,0,0,2'b00,2'b00,1,1,1), "to_ack");
        apply(idle, mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1), "to_sticky");
        chk("to_mw_a", a_mw, 7);
        chk("to_mw_b", 16'(b_mw), 3);

        // Reset asserted in the middle of a WAIT.
        apply(acc, mk(1,1,1,1,0,0,1,2'b00,2'b00,1,0,1), "rw_c0");
        apply(acc, mk(1,1,1,1,0,0,1,2'b00,2'b00,1,1,1), "rw_c1");
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(stall_all);
        pop_check("rw_in_reset");
        chk("rw_mw", a_mw, 0);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        apply(idle, none, "rw_after");

        // Saturation of the narrow counter.
        do_reset();
        for (int i = 0; i < 5; i++)
            apply(lu, mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0,0), $sformatf("sat%0d", i));
        apply(idle, none, "sat_idle");
        chk("sat_lu_a", a_lu, 5);
        chk("sat_lu_b", 16'(b_lu), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. It generates the stall/flush strobes consumed by the pipeline registers (including FlushE into the Execute control register) and the operand-forwarding selects for Execute. It also runs the data-memory wait-state handshake for loads/stores in Memory, freezing the pipeline until the memory acknowledges. Saturating event counters expose hazard statistics.

## Interface
- CNT_W, 16, width of each statistics counter
- TIMEOUT, 255, memory wait cycles before the sticky error flag sets (1..2^16-1)

Ports:
- i_Clk  in  1  single clock, all state on rising edge
- i_Reset  in  1  asynchronous, active-low reset
- i_Rs1D, i_Rs2D  in  5  source registers in Decode
- i_Rs1E, i_Rs2E, i_RdE  in  5  sources/destination in Execute
- i_RdM, i_RdW  in  5  destinations in Memory/Writeback
- i_RegWriteM, i_RegWriteW  in  1  register-write enables, M/W
- i_ResultSrcE  in  2  result select in Execute; 2'b01 = load
- i_PCSrcE  in  1  taken branch/jump resolved in Execute
- i_MemReadM, i_MemWriteM  in  1  data-memory access in Memory
- i_MemAckM  in  1  data-memory acknowledge (may be same-cycle)
- o_StallF, o_StallD, o_StallE, o_StallM  out  1  hold stage register
- o_FlushD, o_FlushE, o_FlushW  out  1  clear stage register
- o_ForwardAE, o_ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- o_MemReqM  out  1  data-memory request
- o_MemBusy  out  1  FSM in WAIT
- o_MemErr  out  1  sticky timeout flag
- o_LoadUseCnt, o_FlushCnt, o_MemWaitCnt  out  CNT_W  saturating statistics

## Operation
- Forwarding, per operand X in {A:Rs1E, B:Rs2E}: 10 if RegWriteM & RdM!=0 & RdM==RsXE; else 01 if RegWriteW & RdW!=0 & RdW==RsXE; else 00. M has priority over W. Computed regardless of stalls.
- o_MemReqM = i_MemReadM | i_MemWriteM (combinational).
- memStall = o_MemReqM & ~i_MemAckM, in either FSM state.
- lwStall = (i_ResultSrcE==2'b01) & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- Priority 1, memStall: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0. Load-use and branch flush are deferred and re-evaluated when the stall releases; E is frozen, so they recur naturally.
- Priority 2, otherwise: StallF=StallD=lwStall, StallE=StallM=FlushW=0, FlushD=PCSrcE, FlushE=lwStall|PCSrcE.
- FSM states and transitions:
  - IDLE → WAIT when memStall.
  - WAIT → IDLE when i_MemAckM.
  - WAIT with no request (request dropped): → IDLE.
- o_MemBusy = (state==WAIT).
- Wait counter: clears in IDLE and increments each WAIT cycle. When it reaches TIMEOUT, o_MemErr sets and stays set until reset. The pipeline keeps stalling; the error does not abort the access.
- Counters saturate at 2^CNT_W-1; no wrap:
  - LoadUseCnt +1 per cycle of lwStall & ~memStall.
  - FlushCnt +1 per cycle of PCSrcE & ~memStall.
  - MemWaitCnt +1 per cycle of memStall.

## Timing
- All strobes, forwards and o_MemReqM are combinational from inputs and state, with zero latency.
- A zero-wait access (ack in the request cycle) causes no stall and no FSM transition.
- An N-cycle-late ack produces exactly N stall cycles. The stall drops in the ack cycle, and the pipeline advances at that edge.
- Reset values (async, any time, including mid-WAIT): state IDLE, wait counter 0, o_MemErr 0, all counters 0.
- During reset, combinational outputs follow inputs; o_MemBusy=0.

## Structure
- hazard_pkg holds:
  - the state enum {IDLE, WAIT};
  - forward constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - RES_LOAD=2'b01.
- sat_counter sub-module (param W; inputs i_Clk, i_Reset, i_Inc; output count) is instantiated three times.

## Test plan
- Forwarding: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5 → ForwardAE=10; RegWriteM=0 → 01; Rs1E=0 → 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, FlushD=0; LoadUseCnt 0→1.
- Branch plus load-use in the same cycle → FlushD=1, FlushE=1, StallF=1; FlushCnt and LoadUseCnt both +1.
- Memory wait: MemReadM=1, ack low 3 cycles then high → 3 cycles of StallF/D/E/M=1 and FlushW=1; o_MemBusy high 3 cycles; MemWaitCnt=3; PCSrcE=1 during the stall gives FlushD=FlushE=0.
- Timeout: TIMEOUT=4, ack held low 6 cycles → o_MemErr rises after the 4th WAIT cycle and stays high after ack. Reset asserted mid-WAIT → IDLE, o_MemErr=0, counters 0.
- Saturation: CNT_W=2, 5 consecutive lwStall cycles → LoadUseCnt=3.
